// File: rtl/mtr_spd_ramp.sv
// Slew-rate limiter in front of the motor driver: clamps signed wheel targets and
// walks lft_spd/rght_spd toward them by at most STEP per ramp tick.
module mtr_spd_ramp #(
    parameter int TICK_DIV = 1024,
    parameter int STEP     = 8,
    parameter int SAT      = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               brake,
    input  logic signed [10:0] lft_tgt,
    input  logic signed [10:0] rght_tgt,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rght_spd,
    output logic               at_tgt,
    output logic               ramping
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic signed [10:0]   SAT_P    = 11'(SAT);
    localparam logic signed [10:0]   SAT_N    = -SAT_P;
    localparam logic signed [10:0]   STEP11   = 11'(STEP);
    localparam logic signed [11:0]   STEP_P12 = 12'(STEP);
    localparam logic signed [11:0]   STEP_N12 = -STEP_P12;

    typedef enum logic [1:0] {IDLE, RUN, STOP, BRAKE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic signed [10:0] eff_l, eff_r;
    logic signed [10:0] nxt_l, nxt_r;

    function automatic logic signed [10:0] clamp(input logic signed [10:0] t);
        if (t > SAT_P)      clamp = SAT_P;
        else if (t < SAT_N) clamp = SAT_N;
        else                clamp = t;
    endfunction

    // One step toward eff; diff is widened so eff - spd can never wrap.
    function automatic logic signed [10:0] ramp(input logic signed [10:0] spd,
                                                input logic signed [10:0] eff);
        logic signed [11:0] diff;
        diff = {eff[10], eff} - {spd[10], spd};
        if (diff > STEP_P12)      ramp = spd + STEP11;
        else if (diff < STEP_N12) ramp = spd - STEP11;
        else                      ramp = eff;
    endfunction

    assign tick = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        eff_l     = '0;
        eff_r     = '0;
        if (state == RUN) begin
            eff_l = clamp(lft_tgt);
            eff_r = clamp(rght_tgt);
        end
        nxt_l = ramp(lft_spd, eff_l);
        nxt_r = ramp(rght_spd, eff_r);
        case (state)
            IDLE:    if (brake) state_nxt = BRAKE;
                     else if (en) state_nxt = RUN;
            RUN:     if (brake) state_nxt = BRAKE;
                     else if (!en) state_nxt = STOP;
            STOP:    if (brake) state_nxt = BRAKE;
                     else if (en) state_nxt = RUN;
                     else if (lft_spd == '0 && rght_spd == '0) state_nxt = IDLE;
            BRAKE:   if (!brake) state_nxt = en ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign at_tgt  = (lft_spd == eff_l) && (rght_spd == eff_r);
    assign ramping = ((state == RUN) || (state == STOP)) && !at_tgt;

    // Brake zeroes outputs and holds the tick counter at 0, overriding any tick step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
        end else begin
            state <= state_nxt;
            if (brake) begin
                cnt      <= '0;
                lft_spd  <= '0;
                rght_spd <= '0;
            end else begin
                cnt <= tick ? '0 : cnt + CW'(1);
                if (tick) begin
                    lft_spd  <= nxt_l;
                    rght_spd <= nxt_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_mtr_spd_ramp.sv
// Bench for mtr_spd_ramp: directed table, hand-written corner sequences and a
// randomized run checked against an arithmetic reference model.
module tb_mtr_spd_ramp;

    localparam int TD = 4;
    localparam int ST = 8;
    localparam int SA = 500;

    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_BRK = 3;

    logic clk, rst, en, brake;
    logic signed [10:0] lft_tgt, rght_tgt, lft_spd, rght_spd;
    logic at_tgt, ramping;
    logic signed [10:0] big_lft_tgt, big_rght_tgt, big_lft_spd, big_rght_spd;
    logic big_at_tgt, big_ramping;

    int n_cmp, n_bad;
    logic signed [10:0] exp_q[$];

    int m_mode, m_cnt, m_l, m_r;

    mtr_spd_ramp #(.TICK_DIV(TD), .STEP(ST), .SAT(SA)) u_dut (
        .clk(clk), .rst(rst), .en(en), .brake(brake),
        .lft_tgt(lft_tgt), .rght_tgt(rght_tgt),
        .lft_spd(lft_spd), .rght_spd(rght_spd),
        .at_tgt(at_tgt), .ramping(ramping)
    );

    mtr_spd_ramp #(.TICK_DIV(TD), .STEP(1023), .SAT(1023)) u_big (
        .clk(clk), .rst(rst), .en(en), .brake(brake),
        .lft_tgt(big_lft_tgt), .rght_tgt(big_rght_tgt),
        .lft_spd(big_lft_spd), .rght_spd(big_rght_spd),
        .at_tgt(big_at_tgt), .ramping(big_ramping)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    function automatic int m_eff(input int tgt);
        if (m_mode != M_RUN) return 0;
        if (tgt > SA) return SA;
        if (tgt < -SA) return -SA;
        return tgt;
    endfunction

    function automatic int toward(input int s, input int e);
        int d;
        d = e - s;
        if (d >= -ST && d <= ST) return e;
        return (d > 0) ? s + ST : s - ST;
    endfunction

    always @(posedge clk or posedge rst) begin
        int el, er, nm;
        if (rst) begin
            m_mode <= M_IDLE; m_cnt <= 0; m_l <= 0; m_r <= 0;
        end else begin
            el = m_eff(int'(lft_tgt));
            er = m_eff(int'(rght_tgt));
            nm = m_mode;
            if (brake) nm = M_BRK;
            else case (m_mode)
                M_IDLE: nm = en ? M_RUN : M_IDLE;
                M_RUN:  nm = en ? M_RUN : M_STOP;
                M_STOP: nm = en ? M_RUN : ((m_l == 0 && m_r == 0) ? M_IDLE : M_STOP);
                default: nm = en ? M_RUN : M_IDLE;
            endcase
            m_mode <= nm;
            if (brake) begin
                m_l <= 0; m_r <= 0; m_cnt <= 0;
            end else begin
                if (m_cnt == TD - 1) begin
                    m_l <= toward(m_l, el);
                    m_r <= toward(m_r, er);
                end
                m_cnt <= (m_cnt + 1) % TD;
            end
        end
    end

    // scoreboard helpers
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model();
        int el, er, eat, erp;
        el  = m_eff(int'(lft_tgt));
        er  = m_eff(int'(rght_tgt));
        eat = (m_l == el && m_r == er) ? 1 : 0;
        erp = ((m_mode == M_RUN || m_mode == M_STOP) && eat == 0) ? 1 : 0;
        chk("rnd_lft_spd", int'(lft_spd), m_l);
        chk("rnd_rght_spd", int'(rght_spd), m_r);
        chk("rnd_at_tgt", int'(at_tgt), eat);
        chk("rnd_ramping", int'(ramping), erp);
    endtask

    // drivers
    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; brake = 1'b0;
        clocks(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic en; logic brake;
        logic signed [10:0] lt; logic signed [10:0] rt;
        int ncyc; int el; int er; int eat; int erp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        n_cmp = 0; n_bad = 0;
        tbl[0] = '{1'b1, 1'b0, 11'sd24, -11'sd20, 4,   8,  -8, 0, 1};
        tbl[1] = '{1'b1, 1'b0, 11'sd24, -11'sd20, 4,  16, -16, 0, 1};
        tbl[2] = '{1'b1, 1'b0, 11'sd24, -11'sd20, 4,  24, -20, 1, 0};
        tbl[3] = '{1'b0, 1'b0, 11'sd24, -11'sd20, 4,  16, -12, 0, 1};
        tbl[4] = '{1'b0, 1'b0, 11'sd24, -11'sd20, 4,   8,  -4, 0, 1};
        tbl[5] = '{1'b0, 1'b0, 11'sd24, -11'sd20, 4,   0,   0, 1, 0};
        tbl[6] = '{1'b0, 1'b0, 11'sd300, -11'sd300, 1, 0,   0, 1, 0};
        tbl[7] = '{1'b0, 1'b0, 11'sd300, -11'sd300, 4, 0,   0, 1, 0};

        rst = 1'b1; en = 1'b0; brake = 1'b0;
        lft_tgt = '0; rght_tgt = '0;
        big_lft_tgt = 11'h400; big_rght_tgt = 11'sd1023;
        clocks(2);
        chk("reset_lft_spd", int'(lft_spd), 0);
        chk("reset_rght_spd", int'(rght_spd), 0);
        chk("reset_at_tgt", int'(at_tgt), 1);
        chk("reset_ramping", int'(ramping), 0);
        rst = 1'b0;

        // table: ramp up, coast down via STOP, then IDLE ignores targets
        for (int i = 0; i < 8; i++) begin
            en = tbl[i].en; brake = tbl[i].brake;
            lft_tgt = tbl[i].lt; rght_tgt = tbl[i].rt;
            clocks(tbl[i].ncyc);
            chk($sformatf("tbl%0d_lft_spd", i), int'(lft_spd), tbl[i].el);
            chk($sformatf("tbl%0d_rght_spd", i), int'(rght_spd), tbl[i].er);
            chk($sformatf("tbl%0d_at_tgt", i), int'(at_tgt), tbl[i].eat);
            chk($sformatf("tbl%0d_ramping", i), int'(ramping), tbl[i].erp);
            if (i == 0) begin
                chk("big_clamp_lft", int'(big_lft_spd), -1023);
                chk("big_rght", int'(big_rght_spd), 1023);
                chk("big_at_tgt", int'(big_at_tgt), 1);
            end
        end

        // brake mid-ramp off a tick, re-ramp, then brake on a tick cycle
        do_reset();
        en = 1'b1; lft_tgt = 11'sd100; rght_tgt = -11'sd100;
        clocks(24);
        chk("pre_brake_lft", int'(lft_spd), 48);
        brake = 1'b1;
        clocks(1);
        chk("brake_lft", int'(lft_spd), 0);
        chk("brake_rght", int'(rght_spd), 0);
        clocks(3);
        chk("brake_hold_lft", int'(lft_spd), 0);
        brake = 1'b0;
        clocks(3);
        chk("rel_wait_lft", int'(lft_spd), 0);
        clocks(1);
        chk("rel_step_lft", int'(lft_spd), 8);
        chk("rel_step_rght", int'(rght_spd), -8);
        clocks(3);
        brake = 1'b1;
        clocks(1);
        chk("brake_on_tick_lft", int'(lft_spd), 0);
        chk("brake_on_tick_rght", int'(rght_spd), 0);
        brake = 1'b0;

        // sign reversal 100 -> -100 through zero
        do_reset();
        en = 1'b1; lft_tgt = 11'sd100; rght_tgt = '0;
        clocks(52);
        chk("rev_start_lft", int'(lft_spd), 100);
        lft_tgt = -11'sd100;
        for (int i = 1; i <= 25; i++) exp_q.push_back(11'(100 - 8 * i));
        for (int i = 1; i <= 25; i++) begin
            clocks(4);
            chk($sformatf("rev_tick%0d", i), int'(lft_spd), int'(exp_q.pop_front()));
        end
        chk("rev_at_tgt", int'(at_tgt), 1);

        // asynchronous reset between edges
        do_reset();
        en = 1'b1; lft_tgt = 11'sd200; rght_tgt = 11'sd200;
        clocks(10);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_lft", int'(lft_spd), 0);
        chk("async_rst_rght", int'(rght_spd), 0);
        chk("async_rst_at_tgt", int'(at_tgt), 1);
        chk("async_rst_ramping", int'(ramping), 0);
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        clocks(3);
        chk("post_rst_wait_lft", int'(lft_spd), 0);
        clocks(1);
        chk("post_rst_step_lft", int'(lft_spd), 8);

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk_model();
            if (brake) begin
                if ($urandom_range(0, 5) == 0) brake = 1'b0;
            end else if ($urandom_range(0, 79) == 0) brake = 1'b1;
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 24) == 0) lft_tgt = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 24) == 0) rght_tgt = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 199) == 0) lft_tgt = -lft_tgt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
